// File: rtl/uart_packet_rx.sv
// ============================================================================
// Module   : uart_packet_rx
// Brief    : Assembles SYNC/CMD/LEN/payload/CHK byte frames into checked
//            packets of 16-bit words, presented on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_packet_rx #(
  parameter int          MAX_WORDS = 4,
  parameter logic [7:0]  SYNC      = 8'hA5,
  parameter int          TIMEOUT   = 200000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  input  logic                    pkt_ready,
  output logic                    pkt_valid,
  output logic [7:0]              pkt_cmd,
  output logic [2:0]              pkt_len,
  output logic [16*MAX_WORDS-1:0] pkt_data,
  output logic                    busy,
  output logic                    err_chk,
  output logic                    err_frame,
  output logic                    err_timeout,
  output logic                    overrun
);

  localparam int               c_TW         = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0]  c_TIMER_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [7:0]       c_MAX_LEN    = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DLO  = 3'd3,
    S_DHI  = 3'd4,
    S_CHK  = 3'd5,
    S_HOLD = 3'd6
  } state_t;

  state_t            r_state;
  logic [7:0]        r_cmd;
  logic [2:0]        r_len;
  logic [7:0]        r_chk;
  logic [2:0]        r_idx;
  logic [c_TW-1:0]   r_timer;
  logic [15:0]       r_words [MAX_WORDS];
  logic [16*MAX_WORDS-1:0] w_words_flat;
  logic              w_in_frame;

  assign w_in_frame = (r_state == S_CMD) || (r_state == S_LEN) ||
                      (r_state == S_DLO) || (r_state == S_DHI) ||
                      (r_state == S_CHK);

  // Working word buffer; cleared at the command byte so short packets read 0 above LEN.
  for (genvar i = 0; i < MAX_WORDS; i++) begin : g_word
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_words[i] <= '0;
      end else if (rx_done) begin
        if (r_state == S_CMD) begin
          r_words[i] <= '0;
        end else if (r_state == S_DLO && r_idx == 3'(i)) begin
          r_words[i][7:0] <= rx_data;
        end else if (r_state == S_DHI && r_idx == 3'(i)) begin
          r_words[i][15:8] <= rx_data;
        end
      end
    end
    assign w_words_flat[16*i +: 16] = r_words[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_len       <= '0;
      r_chk       <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      pkt_valid   <= 1'b0;
      pkt_cmd     <= '0;
      pkt_len     <= '0;
      pkt_data    <= '0;
      busy        <= 1'b0;
      err_chk     <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;

      if (!w_in_frame) begin
        r_timer <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (rx_done && rx_data == SYNC) begin
            r_state <= S_CMD;
            busy    <= 1'b1;
          end
        end

        S_CMD, S_LEN, S_DLO, S_DHI, S_CHK: begin
          if (rx_done) begin
            r_timer <= '0;
            case (r_state)
              S_CMD: begin
                r_cmd   <= rx_data;
                r_chk   <= rx_data;
                r_idx   <= '0;
                r_state <= S_LEN;
              end
              S_LEN: begin
                r_chk <= r_chk ^ rx_data;
                r_len <= rx_data[2:0];
                if (rx_data > c_MAX_LEN) begin
                  err_frame <= 1'b1;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
                end else if (rx_data == 8'd0) begin
                  r_state <= S_CHK;
                end else begin
                  r_state <= S_DLO;
                end
              end
              S_DLO: begin
                r_chk   <= r_chk ^ rx_data;
                r_state <= S_DHI;
              end
              S_DHI: begin
                r_chk <= r_chk ^ rx_data;
                r_idx <= r_idx + 3'd1;
                if (r_idx + 3'd1 == r_len) begin
                  r_state <= S_CHK;
                end else begin
                  r_state <= S_DLO;
                end
              end
              default: begin
                // CHK byte: publish only a verified frame, else keep the last packet.
                if (rx_data == r_chk) begin
                  pkt_cmd   <= r_cmd;
                  pkt_len   <= r_len;
                  pkt_data  <= w_words_flat;
                  pkt_valid <= 1'b1;
                  r_state   <= S_HOLD;
                end else begin
                  err_chk <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
                end
              end
            endcase
          end else if (r_timer == c_TIMER_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            r_timer     <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_HOLD: begin
          if (rx_done) begin
            overrun <= 1'b1;
          end
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_packet_rx.sv
// ============================================================================
// Module   : tb_uart_packet_rx
// Brief    : Directed self-checking bench for uart_packet_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_packet_rx;

  localparam int MAX_WORDS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        pkt_ready = 1'b0;
  logic        pkt_valid;
  logic [7:0]  pkt_cmd;
  logic [2:0]  pkt_len;
  logic [63:0] pkt_data;
  logic        busy, err_chk, err_frame, err_timeout, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_chk = 0, n_frame = 0, n_to = 0, n_over = 0, n_xfer = 0;

  uart_packet_rx #(.MAX_WORDS(MAX_WORDS), .SYNC(8'hA5), .TIMEOUT(50)) u_dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .pkt_ready(pkt_ready), .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd),
    .pkt_len(pkt_len), .pkt_data(pkt_data), .busy(busy), .err_chk(err_chk),
    .err_frame(err_frame), .err_timeout(err_timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pulse and transfer counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_chk)     n_chk++;
      if (err_frame)   n_frame++;
      if (err_timeout) n_to++;
      if (overrun)     n_over++;
      if (pkt_valid && pkt_ready) n_xfer++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    cycles(3);
    check("rst_valid", pkt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", pkt_data, 0);
    check("rst_errs", {err_chk, err_frame, err_timeout, overrun}, 0);
    @(negedge clk);
    reset = 1'b0;
    pkt_ready = 1'b1;

    // Good frame, ready held high
    send(8'hA5);
    check("busy_rise", busy, 1);
    send(8'h01); send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'h0B);
    check("good_valid", pkt_valid, 1);
    check("good_cmd", pkt_cmd, 8'h01);
    check("good_len", pkt_len, 3'd2);
    check("good_data", pkt_data, 64'h0000_0000_5678_1234);
    cycles(1);
    check("good_valid_drop", pkt_valid, 0);
    check("good_busy_drop", busy, 0);
    check("good_xfer", n_xfer, 1);

    // Bad checksum keeps previous packet
    send(8'hA5); send(8'h01); send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'h0C);
    check("chk_pulse", err_chk, 1);
    check("chk_valid", pkt_valid, 0);
    cycles(1);
    check("chk_pulse_end", err_chk, 0);
    check("chk_keep_len", pkt_len, 3'd2);
    check("chk_busy", busy, 0);
    send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
    check("len0_valid", pkt_valid, 1);
    check("len0_cmd", pkt_cmd, 8'h07);
    check("len0_len", pkt_len, 3'd0);
    check("len0_data", pkt_data, 64'd0);
    cycles(1);

    // Garbage ignored, oversized length rejected
    send(8'h11); send(8'h22);
    check("garbage_busy", busy, 0);
    send(8'hA5); send(8'h03); send(8'h05);
    check("frame_pulse", err_frame, 1);
    cycles(1);
    check("frame_busy", busy, 0);

    // Inter-byte timeout
    send(8'hA5); send(8'h01);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_cycles", n, 50);
    check("timeout_busy", busy, 0);
    send(8'hA5); send(8'h03); send(8'h01); send(8'hEF); send(8'hBE); send(8'h53);
    check("post_to_valid", pkt_valid, 1);
    check("post_to_cmd", pkt_cmd, 8'h03);
    check("post_to_data", pkt_data, 64'h0000_0000_0000_BEEF);
    cycles(1);

    // Backpressure with overruns
    pkt_ready = 1'b0;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'h0B);
    send(8'hA5); send(8'h00); send(8'h33);
    cycles(2);
    check("bp_overruns", n_over, 3);
    check("bp_valid", pkt_valid, 1);
    check("bp_cmd", pkt_cmd, 8'h01);
    check("bp_data", pkt_data, 64'h0000_0000_5678_1234);
    n = n_xfer;
    #1;
    pkt_ready = 1'b1;
    cycles(1);
    check("bp_valid_drop", pkt_valid, 0);
    cycles(2);
    check("bp_single_xfer", n_xfer - n, 1);
    send(8'hA5); send(8'h0A); send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    send(8'h86);
    check("full_valid", pkt_valid, 1);
    check("full_len", pkt_len, 3'd4);
    check("full_data", pkt_data, 64'h8877_6655_4433_2211);
    cycles(1);

    // Asynchronous reset mid-frame
    send(8'hA5); send(8'h01); send(8'h02); send(8'h34);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cmd", pkt_cmd, 0);
    check("arst_len", pkt_len, 0);
    check("arst_data", pkt_data, 0);
    cycles(2);
    @(negedge clk);
    reset = 1'b0;
    send(8'hA5); send(8'h02); send(8'h01); send(8'hCD); send(8'hAB); send(8'h65);
    check("post_rst_valid", pkt_valid, 1);
    check("post_rst_cmd", pkt_cmd, 8'h02);
    check("post_rst_data", pkt_data, 64'h0000_0000_0000_ABCD);
    cycles(1);

    // SYNC value inside a frame is plain data
    send(8'hA5); send(8'h04); send(8'h01); send(8'hA5); send(8'hA5); send(8'h05);
    check("sync_data_valid", pkt_valid, 1);
    check("sync_data", pkt_data, 64'h0000_0000_0000_A5A5);
    cycles(2);

    check("tot_err_chk", n_chk, 1);
    check("tot_err_frame", n_frame, 1);
    check("tot_err_timeout", n_to, 1);
    check("tot_overrun", n_over, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
